// File: rtl/pof_shift_pkg.sv
// Shared definitions for the pipelined sticky right shifter.
package pof_shift_pkg;

  // Value of the ARITH parameter that selects a zero-fill (logical) shift.
  localparam int ARITH_LOGICAL = 0;

  // Ceiling log2 with a floor of 1, so a width derived from it is never zero.
  function automatic int clog2_pos(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // Width-independent part of the per-stage record. The data and
  // shift-amount fields depend on module parameters, so they travel as
  // plain vectors alongside this struct.
  typedef struct packed {
    logic valid;   // stage holds a live operand
    logic sticky;  // OR of every original operand bit shifted out so far
    logic sign;    // fill bit for arithmetic shifts, 0 for logical shifts
  } stage_flags_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the logarithmic right shifter: a conditional
// right shift by 2^K with sticky accumulation, followed by a register
// that advances only when the whole pipe is enabled.
module shift_stage
  import pof_shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int AMT_WIDTH = 3,
  parameter int K         = 0,
  parameter int ARITH     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  stage_flags_t         in_flags,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [AMT_WIDTH-1:0] in_amt,
  output stage_flags_t         out_flags,
  output logic [WIDTH-1:0]     out_data,
  output logic [AMT_WIDTH-1:0] out_amt
);

  localparam int SHIFT  = 1 << K;
  // Bits falling off the bottom: the whole word once the step reaches the width.
  localparam int DROP_W = (SHIFT < WIDTH) ? SHIFT : WIDTH;
  // Wide enough to hold (bit index + amount already shifted) without overflow.
  localparam int SUM_W  = clog2_pos(WIDTH + (1 << AMT_WIDTH));

  logic                 fill_bit;
  logic [AMT_WIDTH-1:0] consumed;
  logic [DROP_W-1:0]    true_mask;
  logic [WIDTH-1:0]     shifted;
  logic                 dropped;
  logic [WIDTH-1:0]     data_next;
  stage_flags_t         flags_next;

  assign fill_bit = (ARITH != ARITH_LOGICAL) && in_flags.sign;

  // The full amount is carried down the pipe; the bits below K say how far
  // earlier stages have already shifted, i.e. how many top bits are fill.
  assign consumed = in_amt & AMT_WIDTH'((1 << K) - 1);

  // Marks drop-window positions that still hold original operand bits, so
  // sign fill introduced by earlier stages never reaches the sticky bit.
  always_comb begin
    for (int i = 0; i < DROP_W; i++) begin
      true_mask[i] = (SUM_W'(i) + SUM_W'(consumed)) < SUM_W'(WIDTH);
    end
  end

  generate
    if (SHIFT >= WIDTH) begin : g_full
      assign shifted = {WIDTH{fill_bit}};
    end else begin : g_part
      assign shifted = {{SHIFT{fill_bit}}, in_data[WIDTH-1:SHIFT]};
    end
  endgenerate

  assign dropped = |(in_data[DROP_W-1:0] & true_mask);

  // Apply this stage's shift step when its amount bit is set.
  always_comb begin
    flags_next = in_flags;
    data_next  = in_data;
    if (in_amt[K]) begin
      data_next         = shifted;
      flags_next.sticky = in_flags.sticky | dropped;
    end
  end

  // Stage register; holds everything while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_flags <= '0;
      out_data  <= '0;
      out_amt   <= '0;
    end else if (en) begin
      out_flags <= flags_next;
      out_data  <= data_next;
      out_amt   <= in_amt;
    end
  end

endmodule

// File: rtl/shift_right_sticky_pipe.sv
// Pipelined logarithmic right shifter with sticky output, used to align
// mantissas. One stage per shift-amount bit, valid/ready on both sides,
// and the whole pipe stalls together under backpressure.
module shift_right_sticky_pipe
  import pof_shift_pkg::*;
#(
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 3,
  parameter int DATA_WIDTH_C = 8,
  parameter int ARITH        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH_A-1:0] a,
  input  logic [DATA_WIDTH_B-1:0] b,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH_C-1:0] c,
  output logic                    sticky
);

  localparam int LAST = DATA_WIDTH_B - 1;

  stage_flags_t            stage_flags [DATA_WIDTH_B];
  logic [DATA_WIDTH_A-1:0] stage_data  [DATA_WIDTH_B];
  logic [DATA_WIDTH_B-1:0] stage_amt   [DATA_WIDTH_B];

  stage_flags_t            in_flags;
  logic                    en;
  logic                    out_fill;
  logic                    unused_tail;

  // Single global enable: advance whenever the output slot is empty or draining.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  // Flags entering stage 0: no sticky yet, sign captured only for arithmetic shifts.
  always_comb begin
    in_flags        = '0;
    in_flags.valid  = s_valid;
    in_flags.sign   = (ARITH != ARITH_LOGICAL) && a[DATA_WIDTH_A-1];
  end

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH_B; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        shift_stage #(
          .WIDTH     (DATA_WIDTH_A),
          .AMT_WIDTH (DATA_WIDTH_B),
          .K         (gi),
          .ARITH     (ARITH)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .en        (en),
          .in_flags  (in_flags),
          .in_data   (a),
          .in_amt    (b),
          .out_flags (stage_flags[gi]),
          .out_data  (stage_data[gi]),
          .out_amt   (stage_amt[gi])
        );
      end else begin : g_rest
        shift_stage #(
          .WIDTH     (DATA_WIDTH_A),
          .AMT_WIDTH (DATA_WIDTH_B),
          .K         (gi),
          .ARITH     (ARITH)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .en        (en),
          .in_flags  (stage_flags[gi-1]),
          .in_data   (stage_data[gi-1]),
          .in_amt    (stage_amt[gi-1]),
          .out_flags (stage_flags[gi]),
          .out_data  (stage_data[gi]),
          .out_amt   (stage_amt[gi])
        );
      end
    end
  endgenerate

  assign m_valid  = stage_flags[LAST].valid;
  assign sticky   = stage_flags[LAST].sticky;
  // The sign flag is already zero for logical shifts, so it is the fill directly.
  assign out_fill = stage_flags[LAST].sign;

  // Output resizing: truncate to the low bits, or extend with the fill bit.
  generate
    if (DATA_WIDTH_C <= DATA_WIDTH_A) begin : g_trunc
      assign c = stage_data[LAST][DATA_WIDTH_C-1:0];
    end else begin : g_extend
      assign c = {{(DATA_WIDTH_C - DATA_WIDTH_A){out_fill}}, stage_data[LAST]};
    end
  endgenerate

  // The final amount and, depending on sizing, some data bits have no consumer.
  assign unused_tail = ^{stage_amt[LAST], stage_data[LAST], out_fill};

endmodule

// File: tb/tb_shift_right_sticky_pipe.sv
// Directed bench: a logical and an arithmetic instance driven in lockstep.
module tb_shift_right_sticky_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] a = 8'h00;
  logic [2:0] b = 3'd0;

  logic       s_ready0, m_valid0, sticky0;
  logic       s_ready1, m_valid1, sticky1;
  logic [7:0] c0, c1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_right_sticky_pipe #(
    .DATA_WIDTH_A(8), .DATA_WIDTH_B(3), .DATA_WIDTH_C(8), .ARITH(0)
  ) u_log (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .a(a), .b(b),
    .m_valid(m_valid0), .m_ready(m_ready), .c(c0), .sticky(sticky0)
  );

  shift_right_sticky_pipe #(
    .DATA_WIDTH_A(8), .DATA_WIDTH_B(3), .DATA_WIDTH_C(8), .ARITH(1)
  ) u_ari (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .a(a), .b(b),
    .m_valid(m_valid1), .m_ready(m_ready), .c(c1), .sticky(sticky1)
  );

  typedef struct {
    logic [7:0] a;
    logic [2:0] b;
    logic [7:0] c_log;
    logic       s_log;
    logic [7:0] c_ari;
    logic       s_ari;
  } vec_t;

  vec_t vecs [12];
  int   exp_q [$];
  int   cur_idx = 0;
  int   out_count = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard: outputs must match accepted operands in order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      if (m_valid0) begin
        run_len++;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (m_valid0 && m_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got c=%02h with nothing outstanding, required no output", c0);
        end else begin
          int idx;
          idx = exp_q.pop_front();
          out_count++;
          $display("[TB] out a=%02h b=%0d c_log=%02h s_log=%0b c_ari=%02h s_ari=%0b",
                   vecs[idx].a, vecs[idx].b, c0, sticky0, c1, sticky1);
          chk("c_logical", c0, vecs[idx].c_log);
          chk("sticky_logical", sticky0, vecs[idx].s_log);
          chk("c_arith", c1, vecs[idx].c_ari);
          chk("sticky_arith", sticky1, vecs[idx].s_ari);
          chk("m_valid_arith", m_valid1, 1);
        end
      end
      if (s_valid && s_ready0) exp_q.push_back(cur_idx);
    end
  end

  // Present one operand and hold it until accepted (bounded).
  task automatic send(input int idx);
    int tries;
    tries = 0;
    cur_idx = idx;
    a = vecs[idx].a;
    b = vecs[idx].b;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready0) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
      tries++;
      if (tries > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got s_ready=0 for %0d cycles, required acceptance", tries);
        return;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int oc0;
    //           a       b     c_log  s   c_ari  s
    vecs[0]  = '{8'hB6, 3'd3, 8'h16, 1'b1, 8'hF6, 1'b1};
    vecs[1]  = '{8'hF0, 3'd4, 8'h0F, 1'b0, 8'hFF, 1'b0};
    vecs[2]  = '{8'hF0, 3'd0, 8'hF0, 1'b0, 8'hF0, 1'b0};
    vecs[3]  = '{8'h90, 3'd7, 8'h01, 1'b1, 8'hFF, 1'b1};
    vecs[4]  = '{8'h80, 3'd7, 8'h01, 1'b0, 8'hFF, 1'b0};
    vecs[5]  = '{8'h7F, 3'd7, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[6]  = '{8'h01, 3'd1, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[7]  = '{8'hFF, 3'd1, 8'h7F, 1'b1, 8'hFF, 1'b1};
    vecs[8]  = '{8'h55, 3'd2, 8'h15, 1'b1, 8'h15, 1'b1};
    vecs[9]  = '{8'hC3, 3'd5, 8'h06, 1'b1, 8'hFE, 1'b1};
    vecs[10] = '{8'hA0, 3'd6, 8'h02, 1'b1, 8'hFE, 1'b1};
    vecs[11] = '{8'h0C, 3'd2, 8'h03, 1'b0, 8'h03, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_m_valid", m_valid0, 0);
    chk("reset_c", c0, 0);
    chk("reset_sticky", sticky0, 0);
    chk("reset_s_ready", s_ready0, 1);
    chk("reset_m_valid_arith", m_valid1, 0);
    chk("reset_c_arith", c1, 0);
    @(posedge clk);
    #1;

    // Latency of a single operand is exactly three cycles
    m_ready = 1'b1;
    send(0);
    s_valid = 1'b0;
    @(negedge clk); chk("latency_cycle1", m_valid0, 0);
    @(negedge clk); chk("latency_cycle2", m_valid0, 0);
    @(negedge clk); chk("latency_cycle3", m_valid0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back stream of every table vector
    t0 = cycle;
    for (int i = 0; i < 12; i++) send(i);
    s_valid = 1'b0;
    chk("stream_accept_cycles", cycle - t0, 12);
    repeat (6) @(negedge clk);
    chk("stream_valid_run", last_run, 12);
    chk("stream_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Fill the pipe, stall five cycles, then drain
    oc0 = out_count;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(i);
    cur_idx = 3;
    a = vecs[3].a;
    b = vecs[3].b;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_s_ready", s_ready0, 0);
      chk("stall_m_valid", m_valid0, 1);
      chk("stall_c", c0, vecs[0].c_log);
      chk("stall_sticky", sticky0, vecs[0].s_log);
      chk("stall_c_arith", c1, vecs[0].c_ari);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    send(3);
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("drain_count", out_count - oc0, 4);
    chk("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset with two operands in flight
    send(4);
    send(5);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midreset_m_valid", m_valid0, 0);
    chk("midreset_c", c0, 0);
    chk("midreset_sticky", sticky0, 0);
    chk("midreset_c_arith", c1, 0);
    chk("midreset_sticky_arith", sticky1, 0);
    oc0 = out_count;
    repeat (5) @(negedge clk);
    chk("midreset_no_emit", out_count - oc0, 0);
    @(posedge clk);
    #1;
    send(6);
    s_valid = 1'b0;
    @(negedge clk); chk("post_reset_cycle1", m_valid0, 0);
    @(negedge clk); chk("post_reset_cycle2", m_valid0, 0);
    @(negedge clk); chk("post_reset_cycle3", m_valid0, 1);
    repeat (3) @(negedge clk);
    chk("post_reset_count", out_count - oc0, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
